// File: rtl/eater_pkg.sv
// Shared types and default sizing for the 8-bit computer memory slice.
package eater_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {ST_RUN, ST_PROG, ST_WRITE} prog_state_t;

endpackage

// File: rtl/eater_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with a registered rising-edge detect.
module eater_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/eater_prog_mem.sv
// Program/data RAM with front-panel load mode: synchronised pins, strobe-driven write FSM,
// auto-increment load pointer and a registered CPU read port.
module eater_prog_mem
  import eater_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              prog_strobe,
  input  logic              auto_inc_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] load_ptr,
  output logic [ADDR_W:0]   load_count,
  output logic              load_wrapped
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = DEPTH[ADDR_W:0];

  logic              w_mode;
  logic              w_str_rise;
  prog_state_t       r_state;
  prog_state_t       w_next;
  logic              r_halt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_wrapped;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  eater_sync #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(prog_mode),
    .o_sync (w_mode),
    .o_rise ()
  );

  eater_sync #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(prog_strobe),
    .o_sync (),
    .o_rise (w_str_rise)
  );

  // A strobe edge in PROG wins over a simultaneous mode exit; WRITE then falls to RUN.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RUN:   if (w_mode) w_next = ST_PROG;
      ST_PROG: begin
        if (w_str_rise)   w_next = ST_WRITE;
        else if (!w_mode) w_next = ST_RUN;
      end
      ST_WRITE: w_next = w_mode ? ST_PROG : ST_RUN;
      default:  w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_halt    <= 1'b0;
      r_ptr     <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      r_halt  <= (w_next != ST_RUN);
      r_rdata <= r_mem[cpu_addr];
      if (r_state == ST_RUN && w_next == ST_PROG) begin
        r_ptr     <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end
      if (r_state == ST_PROG && w_next == ST_WRITE) begin
        r_wr_addr <= auto_inc_en ? r_ptr : prog_addr;
        r_wr_data <= prog_data;
      end
      if (r_state == ST_WRITE) begin
        r_ptr <= r_wr_addr + 1'b1;
        if (&r_wr_addr)           r_wrapped <= 1'b1;
        if (r_count != COUNT_MAX) r_count   <= r_count + 1'b1;
      end
    end
  end

  // Single write port; CPU writes only land in RUN, so the loader never collides.
  assign w_mem_we    = (r_state == ST_WRITE) | ((r_state == ST_RUN) & cpu_we);
  assign w_mem_addr  = (r_state == ST_WRITE) ? r_wr_addr : cpu_addr;
  assign w_mem_wdata = (r_state == ST_WRITE) ? r_wr_data : cpu_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign cpu_rdata    = r_rdata;
  assign cpu_halt     = r_halt;
  assign load_ptr     = r_ptr;
  assign load_count   = r_count;
  assign load_wrapped = r_wrapped;

endmodule

// File: tb/tb_eater_prog_mem.sv
// Directed self-checking bench for eater_prog_mem (default 8x16, two-stage synchronisers).
module tb_eater_prog_mem;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog_mode;
  logic              prog_strobe;
  logic              auto_inc_en;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_halt;
  logic [ADDR_W-1:0] load_ptr;
  logic [ADDR_W:0]   load_count;
  logic              load_wrapped;

  int checks   = 0;
  int failures = 0;

  eater_prog_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_mode   (prog_mode),
    .prog_strobe (prog_strobe),
    .auto_inc_en (auto_inc_en),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_halt    (cpu_halt),
    .load_ptr    (load_ptr),
    .load_count  (load_count),
    .load_wrapped(load_wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_prog();
    prog_mode = 1'b1;
    cyc(SYNC + 2);
  endtask

  task automatic exit_prog();
    prog_mode = 1'b0;
    cyc(SYNC + 2);
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d);
    prog_data   = d;
    prog_strobe = 1'b1;
    cyc(SYNC + 3);
    prog_strobe = 1'b0;
    cyc(SYNC + 1);
  endtask

  task automatic read_mem(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    cpu_addr = a;
    cyc(1);
    d = cpu_rdata;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    prog_mode   = 1'($urandom);
    prog_strobe = 1'($urandom);
    auto_inc_en = 1'($urandom);
    prog_addr   = ADDR_W'($urandom);
    prog_data   = DATA_W'($urandom);
    cpu_addr    = ADDR_W'($urandom);
    cpu_we      = 1'b0;
    cpu_wdata   = DATA_W'($urandom);
    cyc(3);
    checks++;
    if (cpu_rdata !== 8'h00 || cpu_halt !== 1'b0 || load_ptr !== 4'd0 ||
        load_count !== 5'd0 || load_wrapped !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: rdata=%h halt=%b ptr=%0d count=%0d wrapped=%b, required 00 0 0 0 0",
               cpu_rdata, cpu_halt, load_ptr, load_count, load_wrapped);
    end
    prog_mode = 1'b0; prog_strobe = 1'b0; auto_inc_en = 1'b0;
    rst_n = 1'b1;
    cyc(SYNC + 3);
    checks++;
    if (cpu_halt !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_run: halt=%b required 0", cpu_halt);
    end
  endtask

  task automatic test_explicit_load();
    logic [DATA_W-1:0] d;
    enter_prog();
    checks++;
    if (cpu_halt !== 1'b1) begin
      failures++;
      $display("FAIL prog_entry_halt: halt=%b required 1", cpu_halt);
    end
    auto_inc_en = 1'b0;
    prog_addr   = 4'd5;
    strobe(8'hA7);
    checks++;
    if (load_count !== 5'd1 || load_ptr !== 4'd6) begin
      failures++;
      $display("FAIL explicit_counters: count=%0d ptr=%0d required 1 6", load_count, load_ptr);
    end
    exit_prog();
    checks++;
    if (cpu_halt !== 1'b0) begin
      failures++;
      $display("FAIL prog_exit_halt: halt=%b required 0", cpu_halt);
    end
    read_mem(4'd5, d);
    checks++;
    if (d !== 8'hA7) begin
      failures++;
      $display("FAIL explicit_read: mem[5]=%h required a7", d);
    end
  endtask

  task automatic test_auto_increment();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
    enter_prog();
    checks++;
    if (load_count !== 5'd0 || load_ptr !== 4'd0 || load_wrapped !== 1'b0) begin
      failures++;
      $display("FAIL session_clear: count=%0d ptr=%0d wrapped=%b required 0 0 0",
               load_count, load_ptr, load_wrapped);
    end
    auto_inc_en = 1'b1;
    prog_addr   = 4'd9;
    for (int i = 0; i < 16; i++) strobe(8'h10 + 8'(i));
    checks++;
    if (load_count !== 5'd16 || load_ptr !== 4'd0 || load_wrapped !== 1'b1) begin
      failures++;
      $display("FAIL wrap_at_16: count=%0d ptr=%0d wrapped=%b required 16 0 1",
               load_count, load_ptr, load_wrapped);
    end
    strobe(8'h20);
    checks++;
    if (load_count !== 5'd16 || load_ptr !== 4'd1 || load_wrapped !== 1'b1) begin
      failures++;
      $display("FAIL saturate_17: count=%0d ptr=%0d wrapped=%b required 16 1 1",
               load_count, load_ptr, load_wrapped);
    end
    exit_prog();
    for (int a = 0; a < 16; a++) begin
      exp = (a == 0) ? 8'h20 : 8'h10 + 8'(a);
      read_mem(ADDR_W'(a), d);
      checks++;
      if (d !== exp) begin
        failures++;
        $display("FAIL auto_read: mem[%0d]=%h required %h", a, d, exp);
      end
    end
  endtask

  task automatic test_cpu_port();
    logic [DATA_W-1:0] d;
    cpu_addr  = 4'd3;
    cpu_wdata = 8'h5C;
    cpu_we    = 1'b1;
    cyc(1);
    checks++;
    if (cpu_rdata !== 8'h13) begin
      failures++;
      $display("FAIL read_before_write: rdata=%h required 13", cpu_rdata);
    end
    cpu_we = 1'b0;
    cyc(1);
    checks++;
    if (cpu_rdata !== 8'h5C) begin
      failures++;
      $display("FAIL cpu_write_visible: rdata=%h required 5c", cpu_rdata);
    end
    enter_prog();
    cpu_wdata = 8'hEE;
    cpu_we    = 1'b1;
    cyc(3);
    checks++;
    if (cpu_halt !== 1'b1) begin
      failures++;
      $display("FAIL prog_halt: halt=%b required 1", cpu_halt);
    end
    cpu_we = 1'b0;
    exit_prog();
    read_mem(4'd3, d);
    checks++;
    if (d !== 8'h5C) begin
      failures++;
      $display("FAIL cpu_we_blocked: mem[3]=%h required 5c", d);
    end
  endtask

  task automatic test_exit_with_strobe();
    logic [DATA_W-1:0] d;
    enter_prog();
    auto_inc_en = 1'b1;
    prog_data   = 8'h77;
    prog_mode   = 1'b0;
    prog_strobe = 1'b1;
    cyc(SYNC + 4);
    checks++;
    if (cpu_halt !== 1'b0 || load_count !== 5'd1 || load_ptr !== 4'd1) begin
      failures++;
      $display("FAIL exit_strobe_write: halt=%b count=%0d ptr=%0d required 0 1 1",
               cpu_halt, load_count, load_ptr);
    end
    read_mem(4'd0, d);
    checks++;
    if (d !== 8'h77) begin
      failures++;
      $display("FAIL exit_strobe_data: mem[0]=%h required 77", d);
    end
    enter_prog();
    cyc(4);
    checks++;
    if (cpu_halt !== 1'b1 || load_count !== 5'd0 || load_ptr !== 4'd0) begin
      failures++;
      $display("FAIL held_strobe_reentry: halt=%b count=%0d ptr=%0d required 1 0 0",
               cpu_halt, load_count, load_ptr);
    end
    prog_strobe = 1'b0;
    exit_prog();
  endtask

  task automatic test_reset_in_write();
    enter_prog();
    auto_inc_en = 1'b0;
    prog_addr   = 4'd2;
    strobe(8'h42);
    checks++;
    if (load_count !== 5'd1 || load_ptr !== 4'd3) begin
      failures++;
      $display("FAIL pre_reset_load: count=%0d ptr=%0d required 1 3", load_count, load_ptr);
    end
    prog_addr   = 4'd8;
    prog_data   = 8'h99;
    prog_strobe = 1'b1;
    cyc(SYNC + 1);
    rst_n       = 1'b0;
    prog_mode   = 1'b0;
    prog_strobe = 1'b0;
    cyc(1);
    checks++;
    if (cpu_halt !== 1'b0 || load_count !== 5'd0 || load_ptr !== 4'd0 || load_wrapped !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_write: halt=%b count=%0d ptr=%0d wrapped=%b required 0 0 0 0",
               cpu_halt, load_count, load_ptr, load_wrapped);
    end
    rst_n = 1'b1;
    cyc(SYNC + 2);
    checks++;
    if (cpu_halt !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_run: halt=%b required 0", cpu_halt);
    end
  endtask

  initial begin
    test_reset();
    test_explicit_load();
    test_auto_increment();
    test_cpu_port();
    test_exit_with_strobe();
    test_reset_in_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
